// File: rtl/getir_ps_uretici_pkg.sv
// getir_ps_uretici_pkg: shared fetch-stage types, redirect codes, opcode constants and helpers.
package getir_ps_uretici_pkg;

    typedef enum logic [1:0] {
        ATLAMAMALIYDI = 2'd0,
        ATLAMALIYDI   = 2'd1,
        SORUN_YOK     = 2'd2
    } hata_e;

    typedef enum logic [1:0] {
        ISTEK_AT,
        YANIT_BEKLE,
        SUN,
        IPTAL
    } durum_e;

    localparam logic [6:0]  OP_DAL   = 7'b1100011;
    localparam logic [6:0]  OP_JAL   = 7'b1101111;
    localparam logic [1:0]  C_OP1    = 2'b01;
    localparam logic [2:0]  F3_CJAL  = 3'b001;
    localparam logic [2:0]  F3_CJ    = 3'b101;
    localparam logic [2:0]  F3_CBEQZ = 3'b110;
    localparam logic [2:0]  F3_CBNEZ = 3'b111;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    // Sequential successor in halfword units; wraps modulo 2^31.
    function automatic logic [31:1] ardisik(input logic [31:1] ps, input logic ctipi);
        return ps + (ctipi ? 31'd1 : 31'd2);
    endfunction

endpackage

// File: rtl/getir_ps_uretici_if.sv
// getir_ps_uretici_if: instruction-memory request/response bus between fetch (master) and L1 (slave).
interface getir_ps_uretici_if;
    logic        istek_o;
    logic [31:1] ps_o;
    logic        hazir_i;
    logic [31:0] buyruk_i;
    logic        buyruk_gecerli_i;

    modport master (output istek_o, ps_o, input hazir_i, buyruk_i, buyruk_gecerli_i);
    modport slave  (input istek_o, ps_o, output hazir_i, buyruk_i, buyruk_gecerli_i);
endinterface

// File: rtl/getir_ps_uretici_on_cozucu.sv
// getir_on_cozucu: combinational pre-decode of one instruction for the branch predictor lookup.
module getir_on_cozucu
    import getir_ps_uretici_pkg::*;
(
    input  logic [31:0] buyruk_i,
    output logic        ctipi_o,
    output logic        jtipi_o,
    output logic        tahmin_et_o
);
    logic       c_op1, cj, cb, jal, dal;
    logic [2:0] f3;

    assign f3    = buyruk_i[15:13];
    assign c_op1 = buyruk_i[1:0] == C_OP1;
    assign cj    = c_op1 && (f3 == F3_CJAL || f3 == F3_CJ);
    assign cb    = c_op1 && (f3 == F3_CBEQZ || f3 == F3_CBNEZ);
    assign jal   = !ctipi_o && buyruk_i[6:0] == OP_JAL;
    assign dal   = !ctipi_o && buyruk_i[6:0] == OP_DAL;

    assign ctipi_o     = buyruk_i[1:0] != 2'b11;
    assign jtipi_o     = jal || cj;
    assign tahmin_et_o = jal || dal || cj || cb;
endmodule

// File: rtl/getir_ps_uretici.sv
// getir_ps_uretici: fetch PC generator, one-outstanding L1 requester and single-slot decode presenter.
// Optional KIZIL_GETIR_SAYAC_EN adds fetched/redirect counters.
module getir_ps_uretici
    import getir_ps_uretici_pkg::*;
#(
    parameter logic [31:0] BASLANGIC_PS = 32'h4000_0000
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               ddb_durdur_i,
    getir_ps_uretici_if.master l1b,
    output logic [31:1]        ps_o,
    output logic               buyruk_ctipi_o,
    output logic               buyruk_jtipi_o,
    output logic               tahmin_et_o,
    input  logic [31:1]        ongorulen_ps_i,
    input  logic               ongorulen_ps_gecerli_i,
    input  logic [1:0]         hata_duzelt_i,
    input  logic [31:1]        yrt_ps_i,
    input  logic               yrt_buyruk_ctipi_i,
    input  logic [31:1]        atlanan_ps_i,
    output logic [31:0]        coz_buyruk_o,
    output logic [31:1]        coz_ps_o,
    output logic               coz_tahmin_o,
    output logic               coz_gecerli_o
`ifdef KIZIL_GETIR_SAYAC_EN
    ,
    output logic [31:0]        getirilen_sayisi_o,
    output logic [31:0]        duzeltme_sayisi_o
`endif
);
    durum_e      durum_q, durum_d;
    logic [31:1] ps_q, ps_d, coz_ps_q, coz_ps_d, hedef;
    logic [31:0] coz_buyruk_q, coz_buyruk_d;
    logic        coz_tahmin_q, coz_tahmin_d, tahmin_q, tahmin_d;
    logic        ctipi, jtipi, tahmin_et, duzelt, tahmin_al;

    getir_on_cozucu u_on_cozucu (
        .buyruk_i    (coz_buyruk_q),
        .ctipi_o     (ctipi),
        .jtipi_o     (jtipi),
        .tahmin_et_o (tahmin_et)
    );

    assign duzelt    = hata_duzelt_i == ATLAMAMALIYDI || hata_duzelt_i == ATLAMALIYDI;
    assign hedef     = hata_duzelt_i == ATLAMALIYDI ? atlanan_ps_i : ardisik(yrt_ps_i, yrt_buyruk_ctipi_i);
    assign tahmin_al = tahmin_et && ongorulen_ps_gecerli_i;

    assign l1b.istek_o    = durum_q == ISTEK_AT && !rst_i;
    assign l1b.ps_o       = ps_q;
    assign coz_gecerli_o  = durum_q == SUN;
    assign coz_buyruk_o   = coz_buyruk_q;
    assign coz_ps_o       = coz_ps_q;
    assign coz_tahmin_o   = coz_tahmin_q;
    assign ps_o           = coz_ps_q;
    assign buyruk_ctipi_o = coz_gecerli_o && ctipi;
    assign buyruk_jtipi_o = coz_gecerli_o && jtipi;
    assign tahmin_et_o    = coz_gecerli_o && tahmin_et;

    always_comb begin
        durum_d      = durum_q;
        ps_d         = ps_q;
        coz_buyruk_d = coz_buyruk_q;
        coz_ps_d     = coz_ps_q;
        coz_tahmin_d = coz_tahmin_q;
        tahmin_d     = tahmin_q;
        if (duzelt) begin
            // An accepted-but-unanswered request must drain through IPTAL before refetching.
            ps_d     = hedef;
            tahmin_d = 1'b0;
            durum_d  = durum_q == ISTEK_AT ? (l1b.hazir_i ? IPTAL : ISTEK_AT) :
                       durum_q == SUN      ? ISTEK_AT :
                       (l1b.buyruk_gecerli_i ? ISTEK_AT : IPTAL);
        end else begin
            case (durum_q)
                ISTEK_AT: if (l1b.hazir_i) durum_d = YANIT_BEKLE;
                YANIT_BEKLE: if (l1b.buyruk_gecerli_i) begin
                    durum_d      = SUN;
                    coz_buyruk_d = l1b.buyruk_i;
                    coz_ps_d     = ps_q;
                    coz_tahmin_d = tahmin_q;
                end
                SUN: if (!ddb_durdur_i) begin
                    durum_d  = ISTEK_AT;
                    ps_d     = tahmin_al ? ongorulen_ps_i : ardisik(coz_ps_q, ctipi);
                    tahmin_d = tahmin_al;
                end
                default: if (l1b.buyruk_gecerli_i) durum_d = ISTEK_AT;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            durum_q      <= ISTEK_AT;
            ps_q         <= BASLANGIC_PS[31:1];
            coz_buyruk_q <= NOP;
            coz_ps_q     <= '0;
            coz_tahmin_q <= 1'b0;
            tahmin_q     <= 1'b0;
        end else begin
            durum_q      <= durum_d;
            ps_q         <= ps_d;
            coz_buyruk_q <= coz_buyruk_d;
            coz_ps_q     <= coz_ps_d;
            coz_tahmin_q <= coz_tahmin_d;
            tahmin_q     <= tahmin_d;
        end
    end

`ifdef KIZIL_GETIR_SAYAC_EN
    logic tuket;

    assign tuket = durum_q == SUN && !ddb_durdur_i && !duzelt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            getirilen_sayisi_o <= '0;
            duzeltme_sayisi_o  <= '0;
        end else begin
            getirilen_sayisi_o <= getirilen_sayisi_o + {31'd0, tuket};
            duzeltme_sayisi_o  <= duzeltme_sayisi_o + {31'd0, duzelt};
        end
    end
`endif
endmodule

// File: tb/tb_getir_ps_uretici.sv
// tb_getir_ps_uretici: scoreboarded directed bench for getir_ps_uretici with a latency-configurable memory model.
module tb_getir_ps_uretici;
    import getir_ps_uretici_pkg::*;

    typedef struct {
        logic [31:1] ps;
        logic [31:0] buyruk;
        logic        tahmin, c, j, t;
    } tuk_t;

    logic        clk = 1'b0, rst_i = 1'b1, durdur = 1'b0, ong_v = 1'b0, yrt_c = 1'b0;
    logic [31:1] ong_ps = '0, yrt_ps = '0, atl_ps = '0;
    logic [1:0]  hata = 2'd2;
    logic [31:1] ps_o, coz_ps_o;
    logic        ctipi_o, jtipi_o, tahmin_et_o, coz_tahmin_o, coz_gecerli_o;
    logic [31:0] coz_buyruk_o;
`ifdef KIZIL_GETIR_SAYAC_EN
    logic [31:0] getirilen, duzeltme;
`endif

    getir_ps_uretici_if l1b ();

    getir_ps_uretici #(.BASLANGIC_PS(32'h4000_0000)) dut (
        .clk_i                  (clk),
        .rst_i                  (rst_i),
        .ddb_durdur_i           (durdur),
        .l1b                    (l1b),
        .ps_o                   (ps_o),
        .buyruk_ctipi_o         (ctipi_o),
        .buyruk_jtipi_o         (jtipi_o),
        .tahmin_et_o            (tahmin_et_o),
        .ongorulen_ps_i         (ong_ps),
        .ongorulen_ps_gecerli_i (ong_v),
        .hata_duzelt_i          (hata),
        .yrt_ps_i               (yrt_ps),
        .yrt_buyruk_ctipi_i     (yrt_c),
        .atlanan_ps_i           (atl_ps),
        .coz_buyruk_o           (coz_buyruk_o),
        .coz_ps_o               (coz_ps_o),
        .coz_tahmin_o           (coz_tahmin_o),
        .coz_gecerli_o          (coz_gecerli_o)
`ifdef KIZIL_GETIR_SAYAC_EN
        ,
        .getirilen_sayisi_o     (getirilen),
        .duzeltme_sayisi_o      (duzeltme)
`endif
    );

    always #5 clk = ~clk;

    int          testler = 0, hatalar = 0, cyc = 0, son_tuk = -1, gecikme = 1, say = 0;
    logic        aralik_on = 1'b0, bekle = 1'b0;
    logic [31:1] adr, beklenen_adr;
    logic [31:1] istek_q[$];
    tuk_t        tuk_q[$];
    tuk_t        e;
    logic [31:0] mem [bit [30:0]];

    task automatic kontrol(input string ad, input logic [31:0] g, input logic [31:0] b);
        testler++;
        if (g !== b) begin
            hatalar++;
            $display("FAIL %s: gercek=%h beklenen=%h", ad, g, b);
        end
    endtask

    function automatic logic [31:0] oku(input logic [31:1] a);
        return mem.exists(a) ? mem[a] : NOP;
    endfunction

    // Memory: gecikme=1 answers in the cycle after acceptance, larger values add wait cycles.
    always @(posedge clk) begin
        cyc++;
        if (rst_i) begin
            l1b.buyruk_gecerli_i <= 1'b0;
            bekle <= 1'b0;
        end else begin
            l1b.buyruk_gecerli_i <= 1'b0;
            if (bekle) begin
                if (say == 0) begin
                    l1b.buyruk_gecerli_i <= 1'b1;
                    l1b.buyruk_i <= oku(adr);
                    bekle <= 1'b0;
                end else say <= say - 1;
            end
            if (l1b.istek_o && l1b.hazir_i) begin
                if (gecikme == 1) begin
                    l1b.buyruk_gecerli_i <= 1'b1;
                    l1b.buyruk_i <= oku(l1b.ps_o);
                end else begin
                    bekle <= 1'b1;
                    adr <= l1b.ps_o;
                    say <= gecikme - 2;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_i) begin
            if (l1b.istek_o && l1b.hazir_i) begin
                if (istek_q.size() == 0) begin
                    testler++;
                    hatalar++;
                    $display("FAIL istek: beklenmeyen adres gercek=%h beklenen=yok", l1b.ps_o);
                end else begin
                    beklenen_adr = istek_q.pop_front();
                    kontrol("istek_ps", {1'b0, l1b.ps_o}, {1'b0, beklenen_adr});
                end
            end
            if (coz_gecerli_o && !durdur && hata[1]) begin
                if (tuk_q.size() == 0) begin
                    testler++;
                    hatalar++;
                    $display("FAIL tuketim: beklenmeyen ps gercek=%h beklenen=yok", coz_ps_o);
                end else begin
                    e = tuk_q.pop_front();
                    kontrol("coz_ps", {1'b0, coz_ps_o}, {1'b0, e.ps});
                    kontrol("coz_buyruk", coz_buyruk_o, e.buyruk);
                    kontrol("coz_tahmin", {31'd0, coz_tahmin_o}, {31'd0, e.tahmin});
                    kontrol("ctipi", {31'd0, ctipi_o}, {31'd0, e.c});
                    kontrol("jtipi", {31'd0, jtipi_o}, {31'd0, e.j});
                    kontrol("tahmin_et", {31'd0, tahmin_et_o}, {31'd0, e.t});
                    if (aralik_on && son_tuk >= 0) kontrol("aralik", cyc - son_tuk, 3);
                    son_tuk = cyc;
                end
            end
        end
    end

    task automatic tuk(input logic [31:1] ps, input logic [31:0] b, input logic tah, c, j, t);
        istek_q.push_back(ps);
        tuk_q.push_back('{ps, b, tah, c, j, t});
    endtask

    task automatic sifirla();
        rst_i = 1'b1;
        durdur = 1'b0;
        hata = 2'd2;
        l1b.hazir_i = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        kontrol("rst_istek", {31'd0, l1b.istek_o}, 32'd0);
        kontrol("rst_gecerli", {31'd0, coz_gecerli_o}, 32'd0);
        kontrol("rst_buyruk", coz_buyruk_o, 32'h0000_0013);
        kontrol("rst_coz_ps", {1'b0, coz_ps_o}, 32'd0);
        kontrol("rst_tahmin", {31'd0, coz_tahmin_o}, 32'd0);
        kontrol("rst_l1b_ps", {1'b0, l1b.ps_o}, 32'h2000_0000);
`ifdef KIZIL_GETIR_SAYAC_EN
        kontrol("rst_getirilen", getirilen, 32'd0);
        kontrol("rst_duzeltme", duzeltme, 32'd0);
`endif
        @(posedge clk);
        #2;
    endtask

    task automatic birak();
        rst_i = 1'b0;
        @(negedge clk);
        kontrol("ilk_istek", {31'd0, l1b.istek_o}, 32'd1);
    endtask

    task automatic bekle_bitir(input string ad);
        int n = 0;
        while ((istek_q.size() != 0 || tuk_q.size() != 0) && n < 300) begin
            @(posedge clk);
            #2;
            n++;
        end
        kontrol({"bitir_", ad}, istek_q.size() + tuk_q.size(), 32'd0);
        istek_q.delete();
        tuk_q.delete();
    endtask

    task automatic bekle_istek(input logic [31:1] a);
        logic bulundu = 1'b0;
        for (int n = 0; n < 100 && !bulundu; n++) begin
            @(negedge clk);
            bulundu = l1b.istek_o && l1b.hazir_i && l1b.ps_o == a;
        end
        kontrol("istek_bekle", {31'd0, bulundu}, 32'd1);
    endtask

    task automatic bekle_coz(input logic [31:1] a);
        logic bulundu = 1'b0;
        for (int n = 0; n < 100 && !bulundu; n++) begin
            @(negedge clk);
            bulundu = coz_gecerli_o && coz_ps_o == a;
        end
        kontrol("coz_bekle", {31'd0, bulundu}, 32'd1);
    endtask

    initial begin
        l1b.hazir_i = 1'b1;
        // Straight-line NOPs: addresses step by 2, one presentation every 3 cycles.
        mem.delete();
        sifirla();
        for (int i = 0; i < 4; i++) tuk(31'h2000_0000 + 31'(2 * i), NOP, 0, 0, 0, 0);
        aralik_on = 1'b1;
        son_tuk = -1;
        birak();
        bekle_bitir("sirali");
        aralik_on = 1'b0;

        // Compressed stepping, unpredicted JALR, predicted JAL and C.J.
        mem.delete();
        mem[31'h2000_0000] = 32'h0000_0001;
        mem[31'h2000_0001] = 32'h0000_0001;
        mem[31'h2000_0002] = 32'h0000_8067;
        mem[31'h2000_0004] = 32'h0000_006F;
        mem[31'h2000_0042] = 32'h0000_A001;
        ong_v = 1'b1;
        ong_ps = 31'h2000_0040;
        sifirla();
        tuk(31'h2000_0000, 32'h0000_0001, 0, 1, 0, 0);
        tuk(31'h2000_0001, 32'h0000_0001, 0, 1, 0, 0);
        tuk(31'h2000_0002, 32'h0000_8067, 0, 0, 0, 0);
        tuk(31'h2000_0004, 32'h0000_006F, 0, 0, 1, 1);
        tuk(31'h2000_0040, NOP, 1, 0, 0, 0);
        tuk(31'h2000_0042, 32'h0000_A001, 0, 1, 1, 1);
        tuk(31'h2000_0040, NOP, 1, 0, 0, 0);
        birak();
        bekle_bitir("tahmin");

        // Redirects while a response is outstanding: with response, then without (via IPTAL).
        ong_v = 1'b0;
        mem.delete();
        mem[31'h2000_0000] = 32'h0000_0063;
        mem[31'h2000_0002] = 32'hDEAD_BEEF;
        mem[31'h2000_0014] = 32'hDEAD_BEEF;
        gecikme = 1;
        sifirla();
        tuk(31'h2000_0000, 32'h0000_0063, 0, 0, 0, 1);
        istek_q.push_back(31'h2000_0002);
        tuk(31'h2000_0012, NOP, 0, 0, 0, 0);
        istek_q.push_back(31'h2000_0014);
        tuk(31'h2000_0080, NOP, 0, 0, 0, 0);
        birak();
        bekle_istek(31'h2000_0002);
        @(posedge clk);
        #2;
        hata = 2'd0;
        yrt_ps = 31'h2000_0010;
        yrt_c = 1'b0;
        @(posedge clk);
        #2;
        hata = 2'd2;
        bekle_coz(31'h2000_0012);
        gecikme = 3;
        bekle_istek(31'h2000_0014);
        @(posedge clk);
        #2;
        hata = 2'd1;
        atl_ps = 31'h2000_0080;
        @(posedge clk);
        #2;
        hata = 2'd2;
        bekle_bitir("yonlendir");
        gecikme = 1;

        // Stall in SUN holds every output; a redirect during the stall drops the slot.
        mem.delete();
        mem[31'h2000_0000] = 32'h0000_E001;
        sifirla();
        durdur = 1'b1;
        istek_q.push_back(31'h2000_0000);
        tuk(31'h2000_0100, NOP, 0, 0, 0, 0);
        birak();
        bekle_coz(31'h2000_0000);
        for (int i = 0; i < 5; i++) begin
            kontrol("dur_gecerli", {31'd0, coz_gecerli_o}, 32'd1);
            kontrol("dur_buyruk", coz_buyruk_o, 32'h0000_E001);
            kontrol("dur_ps", {1'b0, ps_o}, 32'h2000_0000);
            kontrol("dur_ctipi", {31'd0, ctipi_o}, 32'd1);
            kontrol("dur_jtipi", {31'd0, jtipi_o}, 32'd0);
            kontrol("dur_tahmin_et", {31'd0, tahmin_et_o}, 32'd1);
            kontrol("dur_istek", {31'd0, l1b.istek_o}, 32'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #2;
        hata = 2'd1;
        atl_ps = 31'h2000_0100;
        @(posedge clk);
        #2;
        hata = 2'd2;
        durdur = 1'b0;
        @(negedge clk);
        kontrol("dusen_slot", {31'd0, coz_gecerli_o}, 32'd0);
        bekle_bitir("durdur");

        // Ten consumptions, then two redirects while the request is not accepted.
        mem.delete();
        sifirla();
        for (int i = 0; i < 10; i++) tuk(31'h2000_0000 + 31'(2 * i), NOP, 0, 0, 0, 0);
        birak();
        bekle_bitir("sayac");
        l1b.hazir_i = 1'b0;
        hata = 2'd0;
        yrt_ps = 31'h2000_0030;
        yrt_c = 1'b1;
        @(posedge clk);
        #2;
        @(posedge clk);
        #2;
        hata = 2'd2;
        @(negedge clk);
        kontrol("bekleyen_adres", {1'b0, l1b.ps_o}, 32'h2000_0031);
        kontrol("bekleyen_istek", {31'd0, l1b.istek_o}, 32'd1);
`ifdef KIZIL_GETIR_SAYAC_EN
        kontrol("getirilen", getirilen, 32'd10);
        kontrol("duzeltme", duzeltme, 32'd2);
`endif
        tuk(31'h2000_0031, NOP, 0, 0, 0, 0);
        l1b.hazir_i = 1'b1;
        bekle_bitir("son");

        $display("[TB] %0d tests run, %0d failed", testler, hatalar);
        $finish;
    end
endmodule
